// File: rtl/data_memory_bytelane.sv
// data_memory_bytelane: word RAM with byte/half/word access, fault capture and a sequenced clear (ports: clk, reset, chip_select_d, address, write_data, write_enable, read_enable, size, load_unsigned -> read_data, busy, access_fault, fault_valid, fault_addr)
module data_memory_bytelane #(
  parameter int DEPTH_WORDS    = 128,
  parameter int ADDR_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chip_select_d,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           write_data,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [1:0]            size,
  input  logic                  load_unsigned,
  output logic [31:0]           read_data,
  output logic                  busy,
  output logic                  access_fault,
  output logic                  fault_valid,
  output logic [ADDR_WIDTH-1:0] fault_addr
);
  localparam int IW = $clog2(DEPTH_WORDS);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;
  logic [IW-1:0] clear_ptr;
  logic [31:0] mem [DEPTH_WORDS];
  logic req, bad, ok;
  logic [IW-1:0] idx;
  logic [31:0] word, wdata_rep, load_val;
  logic [3:0] lane_mask;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;
  assign busy = (state == CLEAR) || (CLEAR_ON_RESET && reset);
  assign req = chip_select_d && (read_enable || write_enable);
  assign bad = (size == 2'b11) || (size == 2'b01 && address[0]) || (size == 2'b10 && |address[1:0]) ||
               ({1'b0, address} >= (ADDR_WIDTH+1)'(4 * DEPTH_WORDS));
  assign access_fault = req && bad;
  assign ok = req && !busy && !bad;
  assign idx = address[IW+1:2];
  assign word = mem[idx];
  assign lane_mask = size == 2'b00 ? 4'b0001 << address[1:0] : size == 2'b01 ? (address[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata_rep = size == 2'b00 ? {4{write_data[7:0]}} : size == 2'b01 ? {2{write_data[15:0]}} : write_data;
  assign byte_sel = word[{address[1:0], 3'b000} +: 8];
  assign half_sel = address[1] ? word[31:16] : word[15:0];
  always_comb begin
    load_val = size == 2'b00 ? {{24{!load_unsigned && byte_sel[7]}}, byte_sel} :
               size == 2'b01 ? {{16{!load_unsigned && half_sel[15]}}, half_sel} : word;
    read_data = (ok && read_enable) ? load_val : 32'd0;
  end
  // Memory has no reset path; clearing is done one word per cycle by the sequencer
  always_ff @(posedge clk) begin
    if (state == CLEAR && !reset)
      mem[clear_ptr] <= '0;
    else if (ok && write_enable)
      for (int i = 0; i < 4; i++)
        if (lane_mask[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clear_ptr   <= '0;
      fault_valid <= 1'b0;
      fault_addr  <= '0;
    end else begin
      if (state == CLEAR) begin
        clear_ptr <= clear_ptr + 1'b1;
        if (clear_ptr == IW'(DEPTH_WORDS - 1)) state <= IDLE;
      end
      if (access_fault && !busy && !fault_valid) begin
        fault_valid <= 1'b1;
        fault_addr  <= address;
      end
    end
  end
endmodule
